simon_datapath: RTL and testbench

Datapath for the Simon game: holds the level setting, the stored pattern sequence, the sequence length counter and the playback/repeat index. It executes the command strobes issued by the Simon control FSM and returns the three status flags that FSM branches on. It also drives the four pattern LEDs. Every rising edge of `clk` is one player step, since the clock is the debounced pad-touch pulse.

---
 rtl/simon_pkg.sv | 9 +
 rtl/simon_if.sv | 29 ++
 rtl/simon_pattern_mem.sv | 22 ++
 rtl/simon_datapath.sv | 47 ++++
 tb/tb_simon_datapath.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared widths and LED mode encodings for the Simon control and datapath blocks
package simon_pkg;
    localparam int DEFAULT_PATTERN_W = 4;
    localparam int DEFAULT_ADDR_W    = 6;
    localparam logic [2:0] INPUT    = 3'b001;
    localparam logic [2:0] PLAYBACK = 3'b010;
    localparam logic [2:0] REPEAT   = 3'b100;
    localparam logic [2:0] DONE     = 3'b111;
endpackage

// File: rtl/simon_if.sv
// simon_if: command strobes, player inputs and status flags between Simon control and datapath
interface simon_if
    import simon_pkg::*;
#(
    parameter int PATTERN_W = DEFAULT_PATTERN_W
);
    logic                 level;
    logic [PATTERN_W-1:0] pattern;
    logic                 cnt_count;
    logic                 clr_count;
    logic                 cnt_index;
    logic                 clr_index;
    logic                 read_Memory;
    logic                 w_en;
    logic                 set_level;
    logic                 index_lt_count;
    logic                 input_eq_pattern;
    logic                 is_legal;
    logic [PATTERN_W-1:0] pattern_leds;

    modport master (
        output level, pattern, cnt_count, clr_count, cnt_index, clr_index, read_Memory, w_en, set_level,
        input  index_lt_count, input_eq_pattern, is_legal, pattern_leds
    );
    modport slave (
        input  level, pattern, cnt_count, clr_count, cnt_index, clr_index, read_Memory, w_en, set_level,
        output index_lt_count, input_eq_pattern, is_legal, pattern_leds
    );
endinterface

// File: rtl/simon_pattern_mem.sv
// simon_pattern_mem: pattern sequence store, synchronous write and asynchronous read, no reset
module simon_pattern_mem
    import simon_pkg::*;
#(
    parameter int PATTERN_W = DEFAULT_PATTERN_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [PATTERN_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [PATTERN_W-1:0] rdata
);
    logic [PATTERN_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/simon_datapath.sv
// simon_datapath: level register, pattern memory, sequence count and playback index for Simon;
// executes controller strobes and returns the flags the controller branches on.
module simon_datapath
    import simon_pkg::*;
#(
    parameter int PATTERN_W = DEFAULT_PATTERN_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W
) (
    input logic    clk,
    input logic    rst,
    simon_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [ADDR_W-1:0]    count;
    logic [ADDR_W-1:0]    index;
    logic                 level_q;
    logic [PATTERN_W-1:0] rd;

    // Easy level accepts a single pad; hard level accepts any non-empty chord.
    function automatic logic legal(input logic hard, input logic [PATTERN_W-1:0] p);
        return hard ? |p : $onehot(p);
    endfunction

    always_ff @(posedge clk) begin
        count <= bus.clr_count ? '0 : (bus.cnt_count && count != LAST) ? count + 1'b1 : count;
        index <= bus.clr_index ? '0 : bus.cnt_index ? index + 1'b1 : index;
        if (bus.set_level) level_q <= bus.level;
    end

    simon_pattern_mem #(.PATTERN_W(PATTERN_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (bus.w_en),
        .waddr (count),
        .wdata (bus.pattern),
        .raddr (index),
        .rdata (rd)
    );

    assign bus.index_lt_count   = index < count;
    assign bus.input_eq_pattern = bus.pattern == rd;
    assign bus.is_legal         = legal(level_q, bus.pattern);
    assign bus.pattern_leds     = bus.read_Memory ? rd : bus.pattern;

    // Reset is carried out through the controller's strobes; this flags a controller that omits them.
    a_reset_strobes: assert property (@(posedge clk) rst |-> bus.clr_count && bus.clr_index && bus.set_level);
endmodule

// File: tb/tb_simon_datapath.sv
// tb_simon_datapath: directed scenarios plus randomized steps against a behavioural model of the datapath
module tb_simon_datapath;
    localparam int PW = 4;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_if #(.PATTERN_W(PW)) bus ();
    simon_datapath #(.PATTERN_W(PW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int vectors = 0;
    int errors  = 0;
    int cnt = 0;
    int idx = 0;
    bit lvl = 1'b0;
    logic [PW-1:0] mem_m [DEPTH];
    bit written [DEPTH];

    function automatic bit m_legal(input logic [PW-1:0] p);
        return lvl ? (p != 0) : ($countones(p) == 1);
    endfunction

    task automatic idle();
        rst = 0;
        bus.cnt_count = 0;
        bus.clr_count = 0;
        bus.cnt_index = 0;
        bus.clr_index = 0;
        bus.w_en = 0;
        bus.set_level = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (bus.w_en) begin
            mem_m[cnt] = bus.pattern;
            written[cnt] = 1'b1;
        end
        if (bus.set_level) lvl = bus.level;
        cnt = bus.clr_count ? 0 : bus.cnt_count ? (cnt < DEPTH - 1 ? cnt + 1 : DEPTH - 1) : cnt;
        idx = bus.clr_index ? 0 : bus.cnt_index ? (idx + 1) % DEPTH : idx;
        #1;
        idle();
    endtask

    task automatic do_reset(input bit l);
        rst = 1;
        bus.clr_count = 1;
        bus.clr_index = 1;
        bus.set_level = 1;
        bus.level = l;
        tick();
    endtask

    task automatic set_in(input logic [PW-1:0] p, input bit rm);
        bus.pattern = p;
        bus.read_Memory = rm;
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        set_in(4'b0001, 1'b0);
        vectors++; if (bus.index_lt_count !== 1'b0) begin errors++; $display("FAIL reset_lt: got %b expected 0", bus.index_lt_count); end
        vectors++; if (bus.is_legal !== 1'b1) begin errors++; $display("FAIL reset_legal_0001: got %b expected 1", bus.is_legal); end
        vectors++; if (bus.pattern_leds !== 4'b0001) begin errors++; $display("FAIL reset_leds_switch: got %b expected 0001", bus.pattern_leds); end
        set_in(4'b0011, 1'b0);
        vectors++; if (bus.is_legal !== 1'b0) begin errors++; $display("FAIL reset_legal_0011: got %b expected 0", bus.is_legal); end
    endtask

    task automatic test_hard_level();
        do_reset(1'b1);
        bus.level = 1'b0;
        tick();
        set_in(4'b0110, 1'b0);
        vectors++; if (bus.is_legal !== 1'b1) begin errors++; $display("FAIL hard_legal_0110: got %b expected 1", bus.is_legal); end
        set_in(4'b0000, 1'b0);
        vectors++; if (bus.is_legal !== 1'b0) begin errors++; $display("FAIL hard_legal_0000: got %b expected 0", bus.is_legal); end
    endtask

    task automatic test_write_playback();
        do_reset(1'b0);
        bus.pattern = 4'b0100;
        bus.w_en = 1;
        tick();
        set_in(4'b1011, 1'b1);
        vectors++; if (bus.pattern_leds !== 4'b0100) begin errors++; $display("FAIL play_leds: got %b expected 0100", bus.pattern_leds); end
        vectors++; if (bus.index_lt_count !== 1'b0) begin errors++; $display("FAIL play_lt: got %b expected 0", bus.index_lt_count); end
        vectors++; if (bus.input_eq_pattern !== 1'b0) begin errors++; $display("FAIL play_eq_diff: got %b expected 0", bus.input_eq_pattern); end
        set_in(4'b0100, 1'b1);
        vectors++; if (bus.input_eq_pattern !== 1'b1) begin errors++; $display("FAIL play_eq_same: got %b expected 1", bus.input_eq_pattern); end
    endtask

    task automatic test_two_entry();
        do_reset(1'b0);
        bus.pattern = 4'b0001; bus.w_en = 1; tick();
        bus.cnt_count = 1; tick();
        bus.pattern = 4'b1000; bus.w_en = 1; tick();
        set_in(4'b0001, 1'b1);
        vectors++; if (bus.index_lt_count !== 1'b1) begin errors++; $display("FAIL two_lt_idx0: got %b expected 1", bus.index_lt_count); end
        vectors++; if (bus.input_eq_pattern !== 1'b1) begin errors++; $display("FAIL two_eq_idx0: got %b expected 1", bus.input_eq_pattern); end
        bus.cnt_index = 1;
        tick();
        set_in(4'b1000, 1'b1);
        vectors++; if (bus.index_lt_count !== 1'b0) begin errors++; $display("FAIL two_lt_idx1: got %b expected 0", bus.index_lt_count); end
        vectors++; if (bus.input_eq_pattern !== 1'b1) begin errors++; $display("FAIL two_eq_1000: got %b expected 1", bus.input_eq_pattern); end
        vectors++; if (bus.pattern_leds !== 4'b1000) begin errors++; $display("FAIL two_leds: got %b expected 1000", bus.pattern_leds); end
        set_in(4'b0001, 1'b1);
        vectors++; if (bus.input_eq_pattern !== 1'b0) begin errors++; $display("FAIL two_eq_0001: got %b expected 0", bus.input_eq_pattern); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.pattern = PW'($urandom);
            bus.w_en = 1;
            bus.cnt_count = 1;
            tick();
        end
        for (int i = 0; i <= 4; i++) begin
            set_in(PW'($urandom), 1'b1);
            bus.cnt_index = 1;
            vectors++; if (bus.index_lt_count !== (idx < cnt)) begin errors++; $display("FAIL b2b_lt[%0d]: got %b expected %b", i, bus.index_lt_count, idx < cnt); end
            if (written[idx]) begin
                vectors++; if (bus.pattern_leds !== mem_m[idx]) begin errors++; $display("FAIL b2b_leds[%0d]: got %b expected %b", i, bus.pattern_leds, mem_m[idx]); end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        bus.pattern = 4'b0111; bus.w_en = 1; tick();
        repeat (2) begin bus.cnt_count = 1; tick(); end
        bus.cnt_index = 1; tick();
        bus.clr_index = 1; bus.cnt_index = 1; tick();
        set_in(4'b0111, 1'b1);
        vectors++; if (bus.pattern_leds !== 4'b0111) begin errors++; $display("FAIL clr_index_wins: got %b expected 0111", bus.pattern_leds); end
        vectors++; if (bus.index_lt_count !== 1'b1) begin errors++; $display("FAIL clr_index_lt: got %b expected 1", bus.index_lt_count); end
        repeat (70) begin bus.cnt_count = 1; tick(); end
        bus.pattern = 4'b1010; bus.w_en = 1; tick();
        bus.pattern = 4'b0101; bus.w_en = 1; tick();
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_in(4'b0000, 1'b0);
            vectors++; if (bus.index_lt_count !== (idx < cnt)) begin errors++; $display("FAIL sat_walk_lt[%0d]: got %b expected %b", idx, bus.index_lt_count, idx < cnt); end
            bus.cnt_index = 1;
            tick();
        end
        set_in(4'b0101, 1'b1);
        vectors++; if (bus.index_lt_count !== 1'b0) begin errors++; $display("FAIL sat_lt_63: got %b expected 0", bus.index_lt_count); end
        vectors++; if (bus.pattern_leds !== 4'b0101) begin errors++; $display("FAIL sat_overwrite: got %b expected 0101", bus.pattern_leds); end
        vectors++; if (bus.input_eq_pattern !== 1'b1) begin errors++; $display("FAIL sat_eq: got %b expected 1", bus.input_eq_pattern); end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        repeat (5) begin bus.cnt_count = 1; tick(); end
        repeat (3) begin bus.cnt_index = 1; tick(); end
        set_in(4'b0000, 1'b0);
        vectors++; if (bus.index_lt_count !== 1'b1) begin errors++; $display("FAIL mid_pre_lt: got %b expected 1", bus.index_lt_count); end
        do_reset(1'b1);
        set_in(4'b0000, 1'b0);
        vectors++; if (bus.index_lt_count !== 1'b0) begin errors++; $display("FAIL mid_post_lt: got %b expected 0", bus.index_lt_count); end
        vectors++; if (bus.is_legal !== 1'b0) begin errors++; $display("FAIL mid_legal_0000: got %b expected 0", bus.is_legal); end
        set_in(4'b0110, 1'b0);
        vectors++; if (bus.is_legal !== 1'b1) begin errors++; $display("FAIL mid_legal_0110: got %b expected 1", bus.is_legal); end
    endtask

    task automatic test_random();
        logic [PW-1:0] p;
        bit rm;
        for (int i = 0; i < 300; i++) begin
            bus.clr_count = ($urandom_range(0, 15) == 0);
            bus.cnt_count = ($urandom_range(0, 2) == 0);
            bus.clr_index = ($urandom_range(0, 7) == 0);
            bus.cnt_index = ($urandom_range(0, 1) == 0);
            bus.w_en      = ($urandom_range(0, 2) == 0);
            bus.set_level = ($urandom_range(0, 7) == 0);
            bus.level     = 1'($urandom);
            bus.pattern   = PW'($urandom);
            tick();
            p = PW'($urandom);
            rm = 1'($urandom);
            set_in(p, rm);
            vectors++; if (bus.index_lt_count !== (idx < cnt)) begin errors++; $display("FAIL rnd_lt[%0d]: got %b expected %b", i, bus.index_lt_count, idx < cnt); end
            vectors++; if (bus.is_legal !== m_legal(p)) begin errors++; $display("FAIL rnd_legal[%0d]: got %b expected %b", i, bus.is_legal, m_legal(p)); end
            if (written[idx]) begin
                vectors++; if (bus.input_eq_pattern !== (p == mem_m[idx])) begin errors++; $display("FAIL rnd_eq[%0d]: got %b expected %b", i, bus.input_eq_pattern, p == mem_m[idx]); end
            end
            if (!rm || written[idx]) begin
                vectors++; if (bus.pattern_leds !== (rm ? mem_m[idx] : p)) begin errors++; $display("FAIL rnd_leds[%0d]: got %b expected %b", i, bus.pattern_leds, rm ? mem_m[idx] : p); end
            end
        end
    endtask

    initial begin
        idle();
        bus.level = 0;
        bus.pattern = '0;
        bus.read_Memory = 0;
        test_reset();
        test_hard_level();
        test_write_playback();
        test_two_entry();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
